// File: rtl/tiny16_pkg.sv
// rtl/tiny16_pkg.sv - shared defaults and bus-word layout for the tiny16 input port
package tiny16_pkg;

    typedef logic [7:0] byte_t;

    localparam int DEPTH_DEFAULT    = 4;
    localparam int DEBOUNCE_DEFAULT = 16;

    localparam int READY_BIT = 15;
    localparam int OVF_BIT   = 14;

    // Upper byte carries status flags; bits 13:8 always read as zero.
    function automatic logic [15:0] pack_out(input logic rdy, input logic ovf, input byte_t head);
        logic [15:0] w;
        w            = '0;
        w[READY_BIT] = rdy;
        w[OVF_BIT]   = ovf;
        w[7:0]       = head;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - DEPTH x 8 first-in first-out queue with wrapping pointers
module byte_fifo
    import tiny16_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  byte_t                  push_data,
    input  logic                   pop,
    output byte_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // A pop frees the slot in the same edge, so a push into a full queue is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_port.sv
// rtl/input_port.sv - synchronized, debounced 8-pin input port feeding a byte queue
module input_port
    import tiny16_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in,
    input  logic        rd_en,
    input  logic        out_en,
    output logic [15:0] out,
    output logic        ready,
    output logic        overflow
);

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE);

    byte_t      sync1;
    byte_t      sync2;
    byte_t      cand;
    byte_t      stable;
    logic [7:0] db_cnt;
    logic       push;

    byte_t                  head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop_ok;
    logic                   push_drop;

    // Fires for exactly one cycle: stable catches up to cand on the same edge.
    assign push = (db_cnt == DB_LIMIT) && (cand != stable);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            stable <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand   <= sync2;
                db_cnt <= '0;
            end else if (db_cnt != DB_LIMIT) begin
                db_cnt <= db_cnt + 8'd1;
            end
            if (push) begin
                stable <= cand;
            end
        end
    end

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(cand),
        .pop      (rd_en),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign pop_ok    = rd_en && !fifo_empty;
    assign push_drop = push && fifo_full && !rd_en;

    // A push+pop on a full queue leaves the sticky flag exactly as it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (pop_ok && !(push && fifo_full)) begin
            overflow <= 1'b0;
        end
    end

    assign ready = (fifo_count != '0);
    assign out   = out_en ? pack_out(ready, overflow, head) : 16'h0000;

endmodule

// File: tb/tb_input_port.sv
// tb/tb_input_port.sv - directed self-checking bench for input_port (DEPTH=4, DEBOUNCE=4)
module tb_input_port;

    logic        clk;
    logic        rst;
    logic [7:0]  in;
    logic        rd_en;
    logic        out_en;
    logic [15:0] out;
    logic        ready;
    logic        overflow;

    int total;
    int bad;

    input_port #(
        .DEPTH   (4),
        .DEBOUNCE(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .rd_en   (rd_en),
        .out_en  (out_en),
        .out     (out),
        .ready   (ready),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_once();
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
    endtask

    task automatic load_val(input logic [7:0] v);
        in = v;
        step(10);
    endtask

    task automatic test_reset();
        rst = 1'b1; in = 8'h00; rd_en = 1'b0; out_en = 1'b0;
        step(1);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst: got %b expected 0", ready); end
        step(2);
        rst = 1'b0;
        step(20);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        out_en = 1'b1;
        step(1);
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h expected 0000", out); end
        out_en = 1'b0;
    endtask

    task automatic test_glitch();
        in = 8'h3C;
        step(3);
        in = 8'h00;
        step(20);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL glitch_ready: got %b expected 0", ready); end
    endtask

    task automatic test_latency();
        in = 8'hA5;
        step(7);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL latency_early: got %b expected 0", ready); end
        step(1);
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL latency_ready: got %b expected 1", ready); end
        out_en = 1'b1;
        step(1);
        total++;
        if (out !== 16'h80A5) begin bad++; $display("FAIL latency_out: got %h expected 80a5", out); end
        step(2);
        total++;
        if (out !== 16'h80A5) begin bad++; $display("FAIL out_en_no_pop: got %h expected 80a5", out); end
        pop_once();
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL latency_pop_ready: got %b expected 0", ready); end
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL latency_pop_out: got %h expected 0000", out); end
        out_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_after_pop [4];
        exp_after_pop[0] = 16'h8002;
        exp_after_pop[1] = 16'h8003;
        exp_after_pop[2] = 16'h8004;
        exp_after_pop[3] = 16'h0000;
        for (int v = 1; v <= 5; v++) load_val(8'(v));
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        out_en = 1'b1;
        step(1);
        total++;
        if (out !== 16'hC001) begin bad++; $display("FAIL ovf_out: got %h expected c001", out); end
        for (int i = 0; i < 4; i++) begin
            pop_once();
            total++;
            if (out !== exp_after_pop[i]) begin
                bad++; $display("FAIL ovf_pop%0d: got %h expected %h", i, out, exp_after_pop[i]);
            end
        end
        out_en = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] exp_after_pop [4];
        exp_after_pop[0] = 16'h8013;
        exp_after_pop[1] = 16'h8014;
        exp_after_pop[2] = 16'h8016;
        exp_after_pop[3] = 16'h0000;
        out_en = 1'b1;
        for (int v = 8'h11; v <= 8'h15; v++) load_val(8'(v));
        total++;
        if (out !== 16'hC011) begin bad++; $display("FAIL full_pre: got %h expected c011", out); end
        in = 8'h16;
        step(7);
        pop_once();
        total++;
        if (out !== 16'hC012) begin bad++; $display("FAIL full_push_pop: got %h expected c012", out); end
        for (int i = 0; i < 4; i++) begin
            pop_once();
            total++;
            if (out !== exp_after_pop[i]) begin
                bad++; $display("FAIL full_drain%0d: got %h expected %h", i, out, exp_after_pop[i]);
            end
        end
        out_en = 1'b0;
    endtask

    task automatic test_empty_push_pop();
        out_en = 1'b1;
        in = 8'h21;
        step(7);
        pop_once();
        total++;
        if (out !== 16'h8021) begin bad++; $display("FAIL empty_push_pop: got %h expected 8021", out); end
        pop_once();
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL empty_drain: got %h expected 0000", out); end
        out_en = 1'b0;
    endtask

    task automatic test_reset_midway();
        out_en = 1'b1;
        load_val(8'h31);
        load_val(8'h32);
        load_val(8'h33);
        in = 8'h7E;
        step(3);
        rst = 1'b1;
        step(1);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b expected 0", ready); end
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL mid_rst_out: got %h expected 0000", out); end
        rst = 1'b0;
        step(7);
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL mid_rst_early: got %b expected 0", ready); end
        step(1);
        total++;
        if (out !== 16'h807E) begin bad++; $display("FAIL mid_rst_push: got %h expected 807e", out); end
        step(20);
        pop_once();
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL mid_rst_single: got %h expected 0000", out); end
        out_en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; in = 8'h00; rd_en = 1'b0; out_en = 1'b0;
        test_reset();
        test_glitch();
        test_latency();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_reset_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
